// File: rtl/ptc_tap_encoder.sv
// Encodes the PTC one-hot tap vector back to the 4-bit coarse code, debounces it,
// counts illegal vectors and publishes each new stable code over valid/ready.
module ptc_tap_encoder #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [15:0] tap_vec,
  input  logic        clr_err,
  input  logic        code_ready,
  output logic        code_valid,
  output logic [3:0]  code,
  output logic        code_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_PRESENT,
    S_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_CNT);

  state_t           r_state;
  logic [15:0]      r_tap_q;
  logic             r_smp_v;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pub_vld;
  logic [3:0]       r_code;
  logic             r_code_valid;
  logic             r_code_err;
  logic [7:0]       r_err_cnt;

  logic [3:0]       w_enc;
  logic             w_hot;
  logic             w_multi;
  logic             w_legal;
  logic             w_illegal;
  logic [3:0]       w_cand_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_stable;

  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign code_err   = r_code_err;
  assign err_cnt    = r_err_cnt;

  // Bit 15 has no code slot, so any vector touching it is illegal.
  always_comb begin
    w_enc   = 4'd0;
    w_hot   = 1'b0;
    w_multi = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (r_tap_q[k]) begin
        if (w_hot) w_multi = 1'b1;
        w_hot = 1'b1;
        w_enc = 4'(k + 1);
      end
    end
    w_legal   = !r_tap_q[15] && !w_multi;
    w_illegal = r_smp_v && !w_legal;
  end

  always_comb begin
    w_cand_nx = r_cand;
    w_cnt_nx  = r_cnt;
    if (r_smp_v) begin
      if (!w_legal) begin
        w_cnt_nx = '0;
      end else if (w_enc == r_cand) begin
        if (r_cnt != LP_STABLE) w_cnt_nx = r_cnt + 1'b1;
      end else begin
        w_cand_nx = w_enc;
        w_cnt_nx  = CNT_W'(1);
      end
    end
    w_stable = (w_cnt_nx == LP_STABLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_SEARCH;
      r_tap_q      <= '0;
      r_smp_v      <= 1'b0;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_pub_vld    <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (sample_en) r_tap_q <= tap_vec;
      r_smp_v    <= sample_en;
      r_cand     <= w_cand_nx;
      r_cnt      <= w_cnt_nx;
      r_code_err <= w_illegal;

      if (clr_err)
        r_err_cnt <= '0;
      else if (w_illegal && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;

      case (r_state)
        S_SEARCH: begin
          // Stability is judged on the post-update count so publishing lands on the same edge.
          if (w_stable) begin
            if (w_cand_nx != r_code || !r_pub_vld) begin
              r_code       <= w_cand_nx;
              r_code_valid <= 1'b1;
              r_pub_vld    <= 1'b1;
              r_state      <= S_PRESENT;
            end else begin
              r_state <= S_LOCKED;
            end
          end
        end
        S_PRESENT: begin
          if (code_ready) begin
            r_code_valid <= 1'b0;
            if (w_stable && w_cand_nx != r_code)
              r_state <= S_SEARCH;
            else
              r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (r_smp_v && (!w_legal || w_enc != r_code))
            r_state <= S_SEARCH;
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ptc_tap_encoder.sv
// Randomised and directed bench for ptc_tap_encoder with a behavioural model and code scoreboard.
module tb_ptc_tap_encoder;

  localparam int STABLE = 4;
  localparam int SEEK = 0, WAIT_ACK = 1, HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [15:0] tap_vec;
  logic        clr_err;
  logic        code_ready;
  logic        code_valid;
  logic [3:0]  code;
  logic        code_err;
  logic [7:0]  err_cnt;

  int n_tot  = 0;
  int n_pass = 0;

  // Behavioural model state
  bit          m_smp_v;
  logic [15:0] m_tap;
  int          m_run[$];
  int          m_cand;
  int          m_code;
  bit          m_valid;
  bit          m_pubd;
  bit          m_err;
  int          m_errcnt;
  int          m_mode;
  int          sbq[$];

  ptc_tap_encoder #(.STABLE_CNT(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .tap_vec    (tap_vec),
    .clr_err    (clr_err),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .code       (code),
    .code_err   (code_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_enc(input logic [15:0] v);
    if (v == 16'h0000) return 0;
    if ($countones(v) != 1 || v[15]) return -1;
    for (int k = 0; k < 15; k++) if (v[k]) return k + 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    int e;
    bit hs;
    bit st;
    if (!rst_n) begin
      m_smp_v = 0; m_tap = '0; m_run.delete(); m_cand = 0; m_code = 0;
      m_valid = 0; m_pubd = 0; m_err = 0; m_errcnt = 0; m_mode = SEEK;
      sbq.delete();
    end else begin
      hs    = m_valid && code_ready;
      e     = 0;
      m_err = 0;
      if (m_smp_v) begin
        e = exp_enc(m_tap);
        if (e < 0) begin
          m_run.delete();
          m_err = 1;
        end else begin
          if (e != m_cand) m_run.delete();
          if (m_run.size() < STABLE) m_run.push_back(e);
          m_cand = e;
        end
      end
      if (clr_err) m_errcnt = 0;
      else if (m_err && m_errcnt < 255) m_errcnt++;
      st = (m_run.size() == STABLE);
      case (m_mode)
        SEEK: if (st) begin
          if (m_cand != m_code || !m_pubd) begin
            m_code = m_cand; m_valid = 1; m_pubd = 1; m_mode = WAIT_ACK;
            sbq.push_back(m_cand);
          end else m_mode = HOLD;
        end
        WAIT_ACK: if (hs) begin
          m_valid = 0;
          m_mode = (st && m_cand != m_code) ? SEEK : HOLD;
        end
        default: if (m_smp_v && (e < 0 || e != m_code)) m_mode = SEEK;
      endcase
      m_smp_v = sample_en;
      if (sample_en) m_tap = tap_vec;
    end
  end

  always @(negedge clk) begin
    int expc;
    if ($time > 20) begin
      chk("code_valid", int'(code_valid), int'(m_valid));
      chk("code", int'(code), m_code);
      chk("code_err", int'(code_err), int'(m_err));
      chk("err_cnt", int'(err_cnt), m_errcnt);
      if (rst_n && code_valid && code_ready) begin
        if (sbq.size() == 0) begin
          chk("handshake_without_expected_code", 1, 0);
        end else begin
          expc = sbq.pop_front();
          chk("sb_code", int'(code), expc);
        end
      end
    end
  end

  task automatic cyc(input bit se, input logic [15:0] v, input bit rdy, input bit clr, input bit rst);
    sample_en  = se;
    tap_vec    = v;
    code_ready = rdy;
    clr_err    = clr;
    rst_n      = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    int          r, a, b, len;
    bit          se, rdy, clr, rst;
    sample_en = 0; tap_vec = '0; code_ready = 0; clr_err = 0; rst_n = 0;
    cyc(0, 16'h0000, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 0);
    chk("reset_valid", int'(code_valid), 0);
    chk("reset_code", int'(code), 0);
    chk("reset_errcnt", int'(err_cnt), 0);

    // Latency of first publish, then handshake
    for (int i = 0; i < 4; i++) cyc(1, 16'h0008, 0, 0, 1);
    chk("t1_not_yet", int'(code_valid), 0);
    cyc(1, 16'h0008, 0, 0, 1);
    chk("t1_valid", int'(code_valid), 1);
    chk("t1_code", int'(code), 4);
    cyc(1, 16'h0008, 1, 0, 1);
    chk("t1_acked", int'(code_valid), 0);

    // Zero vector is a legal code 0 first publish
    cyc(0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0000, 0, 0, 1);
    chk("t2_valid", int'(code_valid), 1);
    chk("t2_code", int'(code), 0);
    cyc(0, 16'h0000, 1, 0, 1);

    // Interrupted run must not publish
    cyc(1, 16'h0008, 1, 0, 1);
    cyc(1, 16'h0008, 1, 0, 1);
    cyc(1, 16'h0010, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0008, 1, 0, 1);
    cyc(0, 16'h0000, 1, 0, 1);

    // Illegal vectors, clear, saturation
    cyc(1, 16'h0018, 0, 0, 1);
    cyc(1, 16'h8000, 0, 0, 1);
    cyc(0, 16'h0000, 0, 0, 1);
    chk("t4_errcnt2", int'(err_cnt), 2);
    cyc(0, 16'h0000, 0, 1, 1);
    chk("t4_cleared", int'(err_cnt), 0);
    for (int i = 0; i < 300; i++) cyc(1, 16'h8000, 0, 0, 1);
    cyc(0, 16'h0000, 0, 0, 1);
    chk("t4_saturated", int'(err_cnt), 255);

    // Pending code holds under backpressure; new code follows the handshake
    cyc(0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0008, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 16'h0400, 0, 0, 1);
    chk("t5_held_code", int'(code), 4);
    chk("t5_held_valid", int'(code_valid), 1);
    cyc(1, 16'h0400, 1, 0, 1);
    chk("t5_acked", int'(code_valid), 0);
    cyc(1, 16'h0400, 0, 0, 1);
    chk("t5_repub_valid", int'(code_valid), 1);
    chk("t5_repub_code", int'(code), 11);

    // Reset while presenting drops the code; same vector republishes
    cyc(1, 16'h0400, 0, 0, 0);
    chk("t6_valid", int'(code_valid), 0);
    chk("t6_code", int'(code), 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0400, 0, 0, 1);
    chk("t6_repub_valid", int'(code_valid), 1);
    chk("t6_repub_code", int'(code), 11);
    cyc(1, 16'h0400, 1, 0, 1);

    // Random runs
    for (int run = 0; run < 300; run++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        a = $urandom_range(0, 5);
        v = 16'(1) << a;
      end else if (r == 7) begin
        v = 16'h0000;
      end else if (r == 8) begin
        a = $urandom_range(0, 14);
        b = (a + 1 + $urandom_range(0, 13)) % 15;
        v = (16'(1) << a) | (16'(1) << b);
      end else begin
        v = 16'h8000 | 16'($urandom_range(0, 3));
      end
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        se  = ($urandom_range(0, 9) != 0);
        rdy = ($urandom_range(0, 1) != 0);
        clr = ($urandom_range(0, 49) == 0);
        rst = ($urandom_range(0, 199) != 0);
        cyc(se, v, rdy, clr, rst);
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 16'h0000, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
